// File: rtl/laser_pkg.sv
// Shared types and constants for the laser-coverage host.
package laser_pkg;

  localparam int unsigned N_PTS   = 40;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned R2_MAX  = 16;

  typedef enum logic [2:0] {
    Idle,
    WaitRdy,
    Send,
    WaitDone,
    Score,
    Report
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  // Squared euclidean distance between two 4-bit points; max 2*15^2 = 450 fits 9 bits.
  function automatic logic [8:0] dist2(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                       input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return ({5'b0, dx} * {5'b0, dx}) + ({5'b0, dy} * {5'b0, dy});
  endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational check: is one point within radius 4 of either circle centre.
module laser_cover_chk (
  input  logic [3:0] Px,
  input  logic [3:0] Py,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic       covered
);
  import laser_pkg::*;

  logic [8:0] d2_c1;
  logic [8:0] d2_c2;

  // Inside either centre counts once.
  always_comb begin
    d2_c1   = dist2(C1X, C1Y, Px, Py);
    d2_c2   = dist2(C2X, C2Y, Px, Py);
    covered = (d2_c1 <= 9'(R2_MAX)) || (d2_c2 <= 9'(R2_MAX));
  end

endmodule

// File: rtl/laser_host.sv
// Host-side driver/scorer: holds a point set, streams it to the engine, scores the reply.
module laser_host #(
  parameter int unsigned N_PTS   = laser_pkg::N_PTS,
  parameter int unsigned TIMEOUT = 16383
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LD_EN,
  input  logic [3:0] LD_X,
  input  logic [3:0] LD_Y,
  input  logic       START,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       BUSY,
  output logic       RES_VALID,
  output logic [5:0] COVER,
  output logic       TIMEOUT_ERR
);
  import laser_pkg::*;

  localparam int unsigned IDX_W  = $clog2(N_PTS + 1);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  state_e            state;
  point_t            mem [N_PTS];
  logic [IDX_W-1:0]  wp;
  logic [IDX_W-1:0]  idx;       // k while sending, j while scoring
  logic [IDX_W-1:0]  idx_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              seen_low;
  logic [3:0]        c1x_q, c1y_q, c2x_q, c2y_q;
  logic [5:0]        count;
  logic [5:0]        count_nxt;
  logic              covered;

  laser_cover_chk u_cover_chk (
    .Px      (mem[idx].x),
    .Py      (mem[idx].y),
    .C1X     (c1x_q),
    .C1Y     (c1y_q),
    .C2X     (c2x_q),
    .C2Y     (c2y_q),
    .covered (covered)
  );

  // Next-index and running-score helpers.
  always_comb begin
    idx_nxt   = idx + 1'b1;
    count_nxt = count + 6'(covered);
  end

  assign BUSY = (state != Idle);

  // Round sequencer, point memory and all registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= Idle;
      for (int i = 0; i < N_PTS; i++) mem[i] <= '0;
      wp          <= '0;
      idx         <= '0;
      wait_cnt    <= '0;
      seen_low    <= 1'b0;
      c1x_q       <= '0;
      c1y_q       <= '0;
      c2x_q       <= '0;
      c2y_q       <= '0;
      count       <= '0;
      X           <= '0;
      Y           <= '0;
      RES_VALID   <= 1'b0;
      COVER       <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      unique case (state)
        Idle: begin
          if (LD_EN && (wp < IDX_W'(N_PTS))) begin
            mem[wp] <= '{x: LD_X, y: LD_Y};
            wp      <= wp + 1'b1;
          end
          if (START) state <= WaitRdy;
        end
        WaitRdy: begin
          if (DONE) begin
            state    <= Send;
            idx      <= '0;
            seen_low <= 1'b0;
            X        <= mem[0].x;
            Y        <= mem[0].y;
          end
        end
        Send: begin
          if (idx == IDX_W'(N_PTS - 1)) begin
            state    <= WaitDone;
            idx      <= '0;
            wait_cnt <= '0;
            X        <= '0;
            Y        <= '0;
          end else begin
            idx <= idx_nxt;
            X   <= mem[idx_nxt].x;
            Y   <= mem[idx_nxt].y;
          end
        end
        WaitDone: begin
          if (!DONE) seen_low <= 1'b1;
          // A DONE still high from the ready phase is not a result; require a low first.
          if (DONE && seen_low) begin
            state <= Score;
            idx   <= '0;
            count <= '0;
            c1x_q <= C1X;
            c1y_q <= C1Y;
            c2x_q <= C2X;
            c2y_q <= C2Y;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            state       <= Report;
            RES_VALID   <= 1'b1;
            COVER       <= '0;
            TIMEOUT_ERR <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        Score: begin
          if (idx == IDX_W'(N_PTS - 1)) begin
            state       <= Report;
            idx         <= '0;
            RES_VALID   <= 1'b1;
            COVER       <= count_nxt;
            TIMEOUT_ERR <= 1'b0;
          end else begin
            idx   <= idx_nxt;
            count <= count_nxt;
          end
        end
        Report: begin
          state     <= Idle;
          RES_VALID <= 1'b0;
          wp        <= '0;
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule
